// File: rtl/fifo_stream_drain_pkg.sv
// Shared types and default sizes for the FIFO read-side stream drain.
package fifo_stream_drain_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int BUF_DEPTH_DEF  = 3;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_stream_drain_skid_buf.sv
// Small circular buffer that absorbs the FIFO read latency.
// DEPTH need not be a power of two, so pointers wrap explicitly.
module fifo_stream_drain_skid_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= next_ptr(tail_q);
      end
      if (pop_i) begin
        head_q <= next_ptr(head_q);
      end
      occ_q <= occ_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a valid/ready stream at up to one word per clock,
// counting delivered words and latching FIFO underflow.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      word_count,
  output logic                  err_underflow,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  drain_state_e     state_q;
  logic             inflight_q;
  logic [CNT_W-1:0] word_count_q;
  logic [CNT_W-1:0] word_count_d;
  logic             err_q;
  logic             err_d;

  logic [OCC_W-1:0] occ;
  logic [SUM_W-1:0] fill;
  logic             rd_en;
  logic             pop;

  // Stream handshake: a word transfers on every cycle with m_valid && m_ready;
  // m_valid never depends on m_ready and m_data holds while m_valid && !m_ready.
  assign pop = m_valid && m_ready;

  // Read issue uses only registered occupancy and FIFO flags, so m_ready has no
  // combinational path to fifo_rd_en; a slot is reserved for every in-flight word.
  assign fill  = SUM_W'(occ) + SUM_W'(inflight_q);
  assign rd_en = (state_q == RUN) && !fifo_empty && (fill < SUM_W'(BUF_DEPTH));

  fifo_stream_drain_skid_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_skid_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (fifo_data_out),
    .pop_i       (pop),
    .head_data_o (m_data),
    .occ_o       (occ)
  );

  always_comb begin
    word_count_d = word_count_q;
    if (pop) begin
      word_count_d = word_count_q + 1'b1;
    end
    err_d = err_q | fifo_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      inflight_q   <= rd_en;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state_q <= RUN;
          end else if (occ == '0 && !inflight_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en    = rd_en;
  assign m_valid       = (occ != '0);
  assign word_count    = word_count_q;
  assign err_underflow = err_q;
  assign busy          = (state_q != IDLE);
  assign state_dbg     = state_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fill <= SUM_W'(BUF_DEPTH));

endmodule
